// File: rtl/pact_axi_mem_responder.sv
// AXI slave memory responder: serves burst reads (AR/R) and burst writes
// (AW/W/B) from an internal word-addressed array of DEPTH entries.
//
// Ports:
//   clk, rstnn             clock, synchronous active-low reset
//   sxar* / sxr*           read address request / read data response
//   sxaw* / sxw* / sxb*    write address / write data / write response
// One read and one write may be outstanding at once. The two paths run
// independently; a read of a word written in the same cycle returns the old
// value. The memory array itself is never reset.
module pact_axi_mem_responder #(
   parameter int BW_ADDR     = 32,
   parameter int BW_AXI_DATA = 32,
   parameter int BW_AXI_TID  = 4,
   parameter int DEPTH       = 1024
) (
   input  logic                     clk,
   input  logic                     rstnn,
   input  logic [BW_AXI_TID-1:0]    sxarid,
   input  logic [BW_ADDR-1:0]       sxaraddr,
   input  logic [7:0]               sxarlen,
   input  logic [2:0]               sxarsize,
   input  logic [1:0]               sxarburst,
   input  logic                     sxarvalid,
   output logic                     sxarready,
   output logic [BW_AXI_TID-1:0]    sxrid,
   output logic [BW_AXI_DATA-1:0]   sxrdata,
   output logic [1:0]               sxrresp,
   output logic                     sxrlast,
   output logic                     sxrvalid,
   input  logic                     sxrready,
   input  logic [BW_AXI_TID-1:0]    sxawid,
   input  logic [BW_ADDR-1:0]       sxawaddr,
   input  logic [7:0]               sxawlen,
   input  logic [2:0]               sxawsize,
   input  logic [1:0]               sxawburst,
   input  logic                     sxawvalid,
   output logic                     sxawready,
   input  logic [BW_AXI_TID-1:0]    sxwid,
   input  logic [BW_AXI_DATA-1:0]   sxwdata,
   input  logic [BW_AXI_DATA/8-1:0] sxwstrb,
   input  logic                     sxwlast,
   input  logic                     sxwvalid,
   output logic                     sxwready,
   output logic [BW_AXI_TID-1:0]    sxbid,
   output logic [1:0]               sxbresp,
   output logic                     sxbvalid,
   input  logic                     sxbready
);

   localparam int BW_INDEX = $clog2(DEPTH);
   localparam int BW_BYTE  = $clog2(BW_AXI_DATA / 8);
   localparam int NSTRB    = BW_AXI_DATA / 8;
   localparam logic [2:0]          SIZE_OK = 3'(BW_BYTE);
   localparam logic [BW_INDEX-1:0] IDX_ONE = BW_INDEX'(1);
   localparam logic [7:0]          CNT_ONE = 8'd1;

   typedef enum logic {R_IDLE, R_DATA} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

   logic [BW_AXI_DATA-1:0] r_mem [DEPTH];

   rstate_t               r_rstate, w_rstate_nxt;
   logic [BW_AXI_TID-1:0] r_rid;
   logic [BW_INDEX-1:0]   r_ridx;
   logic [7:0]            r_rcnt;
   logic                  r_rfixed;
   logic                  r_rerr;

   wstate_t               r_wstate, w_wstate_nxt;
   logic [BW_AXI_TID-1:0] r_wid;
   logic [BW_INDEX-1:0]   r_widx;
   logic [7:0]            r_wcnt;
   logic                  r_wfixed;
   logic                  r_werr;

   logic w_ar_hs, w_r_hs, w_rlast;
   logic w_aw_hs, w_w_hs, w_wfinal;
   logic w_unused;

   // Byte offset and upper address bits plus the W id are don't-care.
   assign w_unused = ^{sxaraddr, sxawaddr, sxwid};

   assign w_ar_hs  = sxarvalid & sxarready;
   assign w_r_hs   = sxrvalid & sxrready;
   assign w_rlast  = (r_rcnt == 8'd0);
   assign w_aw_hs  = sxawvalid & sxawready;
   assign w_w_hs   = sxwvalid & sxwready;
   assign w_wfinal = (r_wcnt == 8'd0);

   // ---------------- read path ----------------
   always_ff @(posedge clk) begin
      if (!rstnn) begin
         r_rstate <= R_IDLE;
         r_rcnt   <= '0;
         r_rerr   <= 1'b0;
      end else begin
         r_rstate <= w_rstate_nxt;
         if (w_ar_hs) begin
            r_rid    <= sxarid;
            r_ridx   <= sxaraddr[BW_BYTE +: BW_INDEX];
            r_rcnt   <= sxarlen;
            r_rfixed <= (sxarburst == 2'b00);
            r_rerr   <= (sxarsize != SIZE_OK);
         end else if (w_r_hs && !w_rlast) begin
            if (!r_rfixed)
               r_ridx <= r_ridx + IDX_ONE;
            r_rcnt <= r_rcnt - CNT_ONE;
         end
      end
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      sxarready    = 1'b0;
      sxrvalid     = 1'b0;
      unique case (r_rstate)
         R_IDLE: begin
            sxarready = 1'b1;
            if (sxarvalid)
               w_rstate_nxt = R_DATA;
         end
         R_DATA: begin
            sxrvalid = 1'b1;
            if (sxrready && w_rlast)
               w_rstate_nxt = R_IDLE;
         end
      endcase
   end

   assign sxrid   = r_rid;
   assign sxrdata = r_mem[r_ridx];
   assign sxrlast = w_rlast;
   assign sxrresp = r_rerr ? 2'b10 : 2'b00;

   // ---------------- write path ----------------
   always_ff @(posedge clk) begin
      if (!rstnn) begin
         r_wstate <= W_IDLE;
         r_wcnt   <= '0;
         r_werr   <= 1'b0;
      end else begin
         r_wstate <= w_wstate_nxt;
         if (w_aw_hs) begin
            r_wid    <= sxawid;
            r_widx   <= sxawaddr[BW_BYTE +: BW_INDEX];
            r_wcnt   <= sxawlen;
            r_wfixed <= (sxawburst == 2'b00);
            r_werr   <= (sxawsize != SIZE_OK);
         end else if (w_w_hs) begin
            // wlast must line up with the count; the count alone ends the burst
            if (sxwlast != w_wfinal)
               r_werr <= 1'b1;
            if (!w_wfinal) begin
               if (!r_wfixed)
                  r_widx <= r_widx + IDX_ONE;
               r_wcnt <= r_wcnt - CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstnn && w_w_hs) begin
         for (int b = 0; b < NSTRB; b++) begin
            if (sxwstrb[b])
               r_mem[r_widx][8*b +: 8] <= sxwdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      sxawready    = 1'b0;
      sxwready     = 1'b0;
      sxbvalid     = 1'b0;
      unique case (r_wstate)
         W_IDLE: begin
            sxawready = 1'b1;
            if (sxawvalid)
               w_wstate_nxt = W_DATA;
         end
         W_DATA: begin
            sxwready = 1'b1;
            if (sxwvalid && w_wfinal)
               w_wstate_nxt = W_RESP;
         end
         W_RESP: begin
            sxbvalid = 1'b1;
            if (sxbready)
               w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   assign sxbid   = r_wid;
   assign sxbresp = r_werr ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_pact_axi_mem_responder.sv
// Directed bench for pact_axi_mem_responder (DEPTH=16): write/read bursts,
// strobes, wrap, FIXED, error responses, backpressure, concurrency, reset.
module tb_pact_axi_mem_responder;

   logic        clk = 1'b0;
   logic        rstnn = 1'b0;
   logic [3:0]  sxarid = '0;
   logic [31:0] sxaraddr = '0;
   logic [7:0]  sxarlen = '0;
   logic [2:0]  sxarsize = '0;
   logic [1:0]  sxarburst = '0;
   logic        sxarvalid = 1'b0;
   logic        sxarready;
   logic [3:0]  sxrid;
   logic [31:0] sxrdata;
   logic [1:0]  sxrresp;
   logic        sxrlast;
   logic        sxrvalid;
   logic        sxrready = 1'b0;
   logic [3:0]  sxawid = '0;
   logic [31:0] sxawaddr = '0;
   logic [7:0]  sxawlen = '0;
   logic [2:0]  sxawsize = '0;
   logic [1:0]  sxawburst = '0;
   logic        sxawvalid = 1'b0;
   logic        sxawready;
   logic [3:0]  sxwid = '0;
   logic [31:0] sxwdata = '0;
   logic [3:0]  sxwstrb = '0;
   logic        sxwlast = 1'b0;
   logic        sxwvalid = 1'b0;
   logic        sxwready;
   logic [3:0]  sxbid;
   logic [1:0]  sxbresp;
   logic        sxbvalid;
   logic        sxbready = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] wd [8];
   logic [3:0]  ws [8];
   logic        wl [8];
   logic [31:0] rexp [8];

   pact_axi_mem_responder #(
      .BW_ADDR(32), .BW_AXI_DATA(32), .BW_AXI_TID(4), .DEPTH(16)
   ) dut (
      .clk(clk), .rstnn(rstnn),
      .sxarid(sxarid), .sxaraddr(sxaraddr), .sxarlen(sxarlen),
      .sxarsize(sxarsize), .sxarburst(sxarburst),
      .sxarvalid(sxarvalid), .sxarready(sxarready),
      .sxrid(sxrid), .sxrdata(sxrdata), .sxrresp(sxrresp),
      .sxrlast(sxrlast), .sxrvalid(sxrvalid), .sxrready(sxrready),
      .sxawid(sxawid), .sxawaddr(sxawaddr), .sxawlen(sxawlen),
      .sxawsize(sxawsize), .sxawburst(sxawburst),
      .sxawvalid(sxawvalid), .sxawready(sxawready),
      .sxwid(sxwid), .sxwdata(sxwdata), .sxwstrb(sxwstrb),
      .sxwlast(sxwlast), .sxwvalid(sxwvalid), .sxwready(sxwready),
      .sxbid(sxbid), .sxbresp(sxbresp), .sxbvalid(sxbvalid),
      .sxbready(sxbready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue a write burst from wd/ws/wl; optionally stall B with bready=0.
   task automatic wr(input logic [3:0] id, input logic [31:0] addr,
                     input logic [7:0] len, input logic [2:0] size,
                     input logic [1:0] burst, input logic [1:0] resp,
                     input bit stall);
      int n;
      int s;
      sxawid = id; sxawaddr = addr; sxawlen = len;
      sxawsize = size; sxawburst = burst; sxawvalid = 1'b1;
      n = 0;
      while (!sxawready && n < 20) begin @(negedge clk); n++; end
      chk("aw_wait", 64'(n < 20), 64'd1);
      @(negedge clk);
      sxawvalid = 1'b0;
      chk("w_ready_latency", 64'(sxwready), 64'd1);
      for (int b = 0; b <= int'(len); b++) begin
         sxwdata = wd[b]; sxwstrb = ws[b]; sxwlast = wl[b];
         sxwvalid = 1'b1;
         n = 0;
         while (!sxwready && n < 20) begin @(negedge clk); n++; end
         chk("w_wait", 64'(n < 20), 64'd1);
         @(negedge clk);
      end
      sxwvalid = 1'b0; sxwlast = 1'b0;
      chk("b_latency", 64'(sxbvalid), 64'd1);
      if (stall) begin
         s = int'($urandom_range(1, 3));
         repeat (s) begin
            chk("b_hold_valid", 64'(sxbvalid), 64'd1);
            chk("b_hold_resp", 64'(sxbresp), 64'(resp));
            @(negedge clk);
         end
      end
      sxbready = 1'b1;
      chk("b_id", 64'(sxbid), 64'(id));
      chk("b_resp", 64'(sxbresp), 64'(resp));
      @(negedge clk);
      sxbready = 1'b0;
      chk("aw_ready_after_b", 64'(sxawready), 64'd1);
      chk("b_valid_drop", 64'(sxbvalid), 64'd0);
   endtask

   // Issue a read burst and check every beat against rexp.
   task automatic rd(input logic [3:0] id, input logic [31:0] addr,
                     input logic [7:0] len, input logic [2:0] size,
                     input logic [1:0] burst, input logic [1:0] resp,
                     input bit stall);
      int n;
      int s;
      sxarid = id; sxaraddr = addr; sxarlen = len;
      sxarsize = size; sxarburst = burst; sxarvalid = 1'b1;
      n = 0;
      while (!sxarready && n < 20) begin @(negedge clk); n++; end
      chk("ar_wait", 64'(n < 20), 64'd1);
      @(negedge clk);
      sxarvalid = 1'b0;
      chk("r_latency", 64'(sxrvalid), 64'd1);
      for (int b = 0; b <= int'(len); b++) begin
         if (stall) begin
            s = int'($urandom_range(0, 3));
            sxrready = 1'b0;
            repeat (s) begin
               chk("r_hold_valid", 64'(sxrvalid), 64'd1);
               chk("r_hold_data", 64'(sxrdata), 64'(rexp[b]));
               @(negedge clk);
            end
         end
         sxrready = 1'b1;
         chk("r_valid", 64'(sxrvalid), 64'd1);
         chk("r_data", 64'(sxrdata), 64'(rexp[b]));
         chk("r_id", 64'(sxrid), 64'(id));
         chk("r_resp", 64'(sxrresp), 64'(resp));
         chk("r_last", 64'(sxrlast), 64'(b == int'(len)));
         @(negedge clk);
      end
      sxrready = 1'b0;
      chk("ar_ready_after_r", 64'(sxarready), 64'd1);
      chk("r_valid_drop", 64'(sxrvalid), 64'd0);
   endtask

   initial begin
      // reset
      repeat (2) @(negedge clk);
      chk("rst_rvalid", 64'(sxrvalid), 64'd0);
      chk("rst_bvalid", 64'(sxbvalid), 64'd0);
      chk("rst_wready", 64'(sxwready), 64'd0);
      chk("rst_arready", 64'(sxarready), 64'd1);
      chk("rst_awready", 64'(sxawready), 64'd1);
      rstnn = 1'b1;
      @(negedge clk);

      // INCR write then read at 0x40 (aliases to word 0 with DEPTH=16)
      wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
      for (int i = 0; i < 4; i++) begin ws[i] = 4'hF; wl[i] = (i == 3); end
      wr(4'h5, 32'h40, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0);
      rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
      rd(4'h3, 32'h40, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0);

      // partial strobe on word 5
      wd[0] = 32'hAABBCCDD; ws[0] = 4'hF; wl[0] = 1'b1;
      wr(4'h1, 32'h14, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);
      wd[0] = 32'h11223344; ws[0] = 4'h5;
      wr(4'h2, 32'h14, 8'd0, 3'd2, 2'b01, 2'b00, 1'b1);
      rexp[0] = 32'hAA22CC44;
      rd(4'h7, 32'h14, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);

      // INCR wraps from word 15 to word 0
      wd[0] = 32'hF15; wd[1] = 32'hF00;
      ws[0] = 4'hF; ws[1] = 4'hF; wl[0] = 1'b0; wl[1] = 1'b1;
      wr(4'h9, 32'h3C, 8'd1, 3'd2, 2'b01, 2'b00, 1'b0);
      rexp[0] = 32'hF15; rexp[1] = 32'hF00;
      rd(4'hA, 32'h3C, 8'd1, 3'd2, 2'b01, 2'b00, 1'b0);
      rexp[0] = 32'hF00;
      rd(4'hB, 32'h00, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);

      // FIXED read of word 3
      rexp[0] = 32'h44; rexp[1] = 32'h44; rexp[2] = 32'h44;
      rd(4'hC, 32'h0C, 8'd2, 3'd2, 2'b00, 2'b00, 1'b0);

      // bad arsize: data still returned with SLVERR
      rexp[0] = 32'h22; rexp[1] = 32'h33;
      rd(4'hD, 32'h04, 8'd1, 3'd1, 2'b01, 2'b10, 1'b0);

      // early wlast on beat 2: all beats written, SLVERR
      wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3; wd[3] = 32'hA4;
      for (int i = 0; i < 4; i++) ws[i] = 4'hF;
      wl[0] = 1'b0; wl[1] = 1'b1; wl[2] = 1'b0; wl[3] = 1'b1;
      wr(4'h6, 32'h20, 8'd3, 3'd2, 2'b01, 2'b10, 1'b1);
      rexp[0] = 32'hA1; rexp[1] = 32'hA2; rexp[2] = 32'hA3; rexp[3] = 32'hA4;
      rd(4'h4, 32'h20, 8'd3, 3'd2, 2'b01, 2'b00, 1'b1);
      rd(4'h8, 32'h20, 8'd3, 3'd2, 2'b01, 2'b00, 1'b1);

      // same-cycle read and write of word 10
      wd[0] = 32'h1234; ws[0] = 4'hF; wl[0] = 1'b1;
      wr(4'h1, 32'h28, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);
      sxawid = 4'h2; sxawaddr = 32'h28; sxawlen = 8'd0;
      sxawsize = 3'd2; sxawburst = 2'b01; sxawvalid = 1'b1;
      sxarid = 4'h3; sxaraddr = 32'h28; sxarlen = 8'd0;
      sxarsize = 3'd2; sxarburst = 2'b01; sxarvalid = 1'b1;
      @(negedge clk);
      sxawvalid = 1'b0; sxarvalid = 1'b0;
      sxwdata = 32'h5678; sxwstrb = 4'hF; sxwlast = 1'b1; sxwvalid = 1'b1;
      sxrready = 1'b1;
      chk("cc_rvalid", 64'(sxrvalid), 64'd1);
      chk("cc_wready", 64'(sxwready), 64'd1);
      chk("cc_old_data", 64'(sxrdata), 64'h1234);
      @(negedge clk);
      sxwvalid = 1'b0; sxwlast = 1'b0; sxrready = 1'b0;
      chk("cc_rdone", 64'(sxrvalid), 64'd0);
      chk("cc_bvalid", 64'(sxbvalid), 64'd1);
      chk("cc_bid", 64'(sxbid), 64'h2);
      sxbready = 1'b1;
      @(negedge clk);
      sxbready = 1'b0;
      rexp[0] = 32'h5678;
      rd(4'h5, 32'h28, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);

      // reset in the middle of a read burst
      sxarid = 4'hE; sxaraddr = 32'h00; sxarlen = 8'd3;
      sxarsize = 3'd2; sxarburst = 2'b01; sxarvalid = 1'b1;
      @(negedge clk);
      sxarvalid = 1'b0; sxrready = 1'b1;
      chk("mr_beat0", 64'(sxrdata), 64'hF00);
      @(negedge clk);
      sxrready = 1'b0;
      chk("mr_beat1_valid", 64'(sxrvalid), 64'd1);
      rstnn = 1'b0;
      @(negedge clk);
      chk("mr_rvalid", 64'(sxrvalid), 64'd0);
      chk("mr_arready", 64'(sxarready), 64'd1);
      chk("mr_bvalid", 64'(sxbvalid), 64'd0);
      rstnn = 1'b1;
      @(negedge clk);
      chk("mr_rvalid_after", 64'(sxrvalid), 64'd0);
      rexp[0] = 32'h22; rexp[1] = 32'h33;
      rd(4'h1, 32'h04, 8'd1, 3'd2, 2'b01, 2'b00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pact_axi_mem_responder.md
# pact_axi_mem_responder

AXI slave-side memory responder: the other end of the PACT LSU DMA port. It accepts burst read (AR/R) and burst write (AW/W/B) transactions from an LSU-style initiator and serves them from an internal word-addressed register array of DEPTH entries. It is the scratchpad target behind the LSU in PACT subsystem builds and testbenches, and supports one outstanding read and one outstanding write, processed independently.

## Interface

- BW_ADDR, 32, AXI address width
- BW_AXI_DATA, 32, data width; power of two, at least 8
- BW_AXI_TID, 4, transaction ID width
- DEPTH, 1024, memory words; power of two; BW_INDEX = log2(DEPTH), BW_BYTE = log2(BW_AXI_DATA/8)

Ports:

- clk  in  1  clock
- rstnn  in  1  reset; one clock; reset is synchronous and active-low
- sxarid / sxaraddr / sxarlen / sxarsize / sxarburst  in  BW_AXI_TID / BW_ADDR / `BW_AXI_ALEN / `BW_AXI_ASIZE / `BW_AXI_ABURST  read request
- sxarvalid  in  1; sxarready  out  1
- sxrid  out  BW_AXI_TID; sxrdata  out  BW_AXI_DATA; sxrresp  out  `BW_AXI_RRESP; sxrlast  out  1; sxrvalid  out  1; sxrready  in  1
- sxawid / sxawaddr / sxawlen / sxawsize / sxawburst  in  same widths as AR; sxawvalid  in  1; sxawready  out  1
- sxwid  in  BW_AXI_TID (ignored); sxwdata  in  BW_AXI_DATA; sxwstrb  in  `BW_AXI_WSTRB(BW_AXI_DATA); sxwlast  in  1; sxwvalid  in  1; sxwready  out  1
- sxbid  out  BW_AXI_TID; sxbresp  out  `BW_AXI_BRESP; sxbvalid  out  1; sxbready  in  1

## Operation

- Word index = addr[BW_BYTE+BW_INDEX-1 : BW_BYTE]. Low byte bits and upper bits are ignored, so addresses alias modulo DEPTH words.
- Burst length = alen+1. FIXED (2'b00) keeps the index constant. INCR (2'b01), and WRAP/reserved (treated as INCR), increment the index by 1 per beat, wrapping from DEPTH-1 to 0.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: sxarready=1. On the AR handshake, latch id, index, remaining count = arlen, burst type, and error flag = (arsize != BW_BYTE); go to R_DATA.
  - R_DATA: sxrvalid=1, sxrdata = mem[index] (combinational array read), sxrid = latched id, sxrlast = (count==0), sxrresp = 2'b10 if the error flag is set, else 2'b00.
  - On each R handshake: if last, go to R_IDLE; otherwise advance the index and decrement count.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: sxawready=1, sxwready=0. On the AW handshake, latch id, index, count, burst, and error = (awsize != BW_BYTE); go to W_DATA.
  - W_DATA: sxwready=1. On each W handshake, write byte lanes of mem[index] where wstrb is 1; other lanes are kept.
  - Set error if sxwlast=1 on a non-final beat, or sxwlast=0 on the final beat.
  - Termination is decided only by count: the final beat goes to W_RESP. Beats beyond the burst are never accepted (wready=0).
  - W_RESP: sxbvalid=1, sxbid = latched id, sxbresp = 2'b10 if error, else 2'b00. The B handshake goes to W_IDLE.
- Read and write run concurrently. On the same word in the same cycle, R returns the pre-write value; the write is visible from the next cycle.
- Memory content is not initialised and not cleared by reset.

## Timing

- Reset: the first clk edge with rstnn=0 forces R_IDLE/W_IDLE and clears error flags and counters.
  - Outputs during and after reset: sxrvalid=0, sxbvalid=0, sxwready=0, sxarready=1, sxawready=1.
  - sxrdata/sxrid/sxbid/sxrresp/sxbresp/sxrlast are don't-care while their valid is 0.
  - A mid-burst reset aborts the transaction silently: no further R beats or B response.
- AR handshake at cycle N -> first sxrvalid at N+1; one beat per cycle when sxrready is held 1.
- Last R handshake at cycle M -> sxarready=1 at M+1, so there is a one-cycle bubble between back-to-back reads.
- AW handshake at N -> sxwready from N+1. Final W handshake at M -> sxbvalid at M+1. B handshake at K -> sxawready at K+1.
- R and B outputs stay stable while valid=1 and ready=0.
- All ready/valid outputs are decoded from registered state only; there are no combinational input-to-output paths except sxrdata from the array.

## Test plan

- Write then read, INCR: AW addr 0x40, len 3, wdata 0x11..0x44, strb 0xF. Required: B resp 0, bid = awid. Then AR addr 0x40, len 3 -> four R beats 0x11,0x22,0x33,0x44, rlast only on beat 4, first rvalid one cycle after the AR handshake.
- Partial strobe: mem[5]=0xAABBCCDD; write 0x11223344 with strb 0x5 -> read returns 0xAA22CC44.
- Wrap-around and FIXED burst (DEPTH=16):
  - INCR write at word 15, len 1 -> writes words 15 and 0.
  - FIXED read len 2 of word 3 -> three identical beats.
- Errors:
  - arsize=1 -> all beats return rresp 2'b10 with data.
  - wlast asserted on beat 2 of a len-3 burst -> all 4 beats written, bresp 2'b10.
- Backpressure and concurrency:
  - Random sxrready/sxbready stalls -> outputs held stable, no beat lost.
  - Simultaneous read and write of the same word -> R shows the old value.
  - Reset asserted mid-R-burst -> rvalid=0 after the edge, arready=1, memory retained.
